// File: rtl/dtpu_pkg.sv
// Shared dtpu definitions: default FIFO geometry used by dtpu_core and the
// stream FIFO, plus a constant-evaluable clog2 helper.
package dtpu_pkg;

  localparam int DTPU_FIFO_DATA_WIDTH = 64;
  localparam int DTPU_FIFO_DEPTH      = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/dtpu_fifo_ram.sv
// Simple dual-port storage for the stream FIFO: synchronous write,
// asynchronous read, deliberately without reset.
module dtpu_fifo_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dtpu_stream_fifo.sv
// Parametrised stream FIFO with the dtpu_core handshake: FWFT or registered
// read, almost-full/empty thresholds, occupancy, flush and sticky errors.
module dtpu_stream_fifo
  import dtpu_pkg::*;
#(
  parameter int DATA_WIDTH    = DTPU_FIFO_DATA_WIDTH,
  parameter int DEPTH         = DTPU_FIFO_DEPTH,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2,
  parameter bit FWFT          = 1'b1
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      enable,
  input  logic                      flush,
  input  logic                      write,
  input  logic [DATA_WIDTH-1:0]     din,
  output logic                      is_full,
  output logic                      almost_full,
  input  logic                      read,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      is_empty,
  output logic                      almost_empty,
  output logic [clog2(DEPTH):0]     count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clear_err
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0]     r_wrPtr;
  logic [ADDR_W-1:0]     r_rdPtr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_afull;
  logic                  r_aempty;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_active;
  logic                  w_doFlush;
  logic                  w_rdAcc;
  logic                  w_wrAcc;
  logic                  w_ovfEvt;
  logic                  w_udfEvt;
  logic                  w_clrErr;
  logic [CNT_W-1:0]      w_countNext;
  logic [DATA_WIDTH-1:0] w_ramData;

  // A write into a full FIFO is only legal when a read frees a slot this cycle.
  assign w_active  = enable & ~flush;
  assign w_doFlush = enable & flush;
  assign w_rdAcc   = w_active & read & (r_count != '0);
  assign w_wrAcc   = w_active & write & ((r_count != CNT_W'(DEPTH)) | w_rdAcc);
  assign w_ovfEvt  = w_active & write & ~w_wrAcc;
  assign w_udfEvt  = w_active & read & ~w_rdAcc;
  assign w_clrErr  = enable & clear_err;

  always_comb begin
    w_countNext = r_count;
    if (w_doFlush) begin
      w_countNext = '0;
    end else begin
      w_countNext = r_count + CNT_W'(w_wrAcc) - CNT_W'(w_rdAcc);
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_afull  <= (AFULL_THRESH == 0);
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_doFlush) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
      end else begin
        if (w_wrAcc) r_wrPtr <= r_wrPtr + 1'b1;
        if (w_rdAcc) r_rdPtr <= r_rdPtr + 1'b1;
      end
      r_count  <= w_countNext;
      r_empty  <= (w_countNext == '0);
      r_full   <= (w_countNext == CNT_W'(DEPTH));
      r_afull  <= (int'(w_countNext) >= AFULL_THRESH);
      r_aempty <= (int'(w_countNext) <= AEMPTY_THRESH);
      // A fresh error in the same cycle as clear_err must survive the clear.
      r_ovf    <= w_ovfEvt | (r_ovf & ~w_clrErr);
      r_udf    <= w_udfEvt | (r_udf & ~w_clrErr);
    end
  end

  dtpu_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wrAcc),
    .i_waddr (r_wrPtr),
    .i_wdata (din),
    .i_raddr (r_rdPtr),
    .o_rdata (w_ramData)
  );

  generate
    if (FWFT) begin : g_fwft
      assign dout = w_ramData;
    end else begin : g_regRead
      logic [DATA_WIDTH-1:0] r_dout;
      always_ff @(posedge clk) begin
        if (!aresetn) begin
          r_dout <= '0;
        end else if (w_rdAcc) begin
          r_dout <= w_ramData;
        end
      end
      assign dout = r_dout;
    end
  endgenerate

  assign count        = r_count;
  assign is_empty     = r_empty;
  assign is_full      = r_full;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule
